// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the sequential multiplier.
package mult_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned P_W   = 16;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned ACC_W = OP_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_stage.sv
// One shift-and-add multiplier step (combinational).
//   acc      : 9-bit partial-product accumulator (acc[8] is always 0 between steps)
//   mq       : multiplier / low product bits, LSB selects the add
//   mcand    : multiplicand
//   acc_nxt  : accumulator after add and right shift
//   mq_nxt   : multiplier/low product after right shift
module shift_add_stage
  import mult_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [OP_W-1:0]  mq,
  input  logic [OP_W-1:0]  mcand,
  output logic [ACC_W-1:0] acc_nxt,
  output logic [OP_W-1:0]  mq_nxt
);

  logic [OP_W-1:0]  addend;
  logic [ACC_W-1:0] sum;

  // Carry out of the add lands in sum[8] and is shifted into acc, never lost.
  always_comb begin
    addend  = mq[0] ? mcand : '0;
    sum     = acc + {1'b0, addend};
    acc_nxt = {1'b0, sum[ACC_W-1:1]};
    mq_nxt  = {sum[0], mq[OP_W-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier with start/ready handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, accepted only while ready=1
//   a, b       : multiplicand / multiplier
//   ready      : IDLE or DONE, can accept start
//   busy       : iteration in progress
//   done       : one-cycle pulse, p/ovf valid
//   p          : 16-bit product, held until the next operation completes
//   ovf        : product does not fit in 8 bits
module seq_multiplier
  import mult_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [P_W-1:0]  p,
  output logic            ovf
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [OP_W-1:0]  mq, mq_nxt;
  logic [OP_W-1:0]  mcand;
  logic             load;
  logic             step;
  logic             finish;

  shift_add_stage u_stage (
    .acc     (acc),
    .mq      (mq),
    .mcand   (mcand),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  // Status decoded straight from the state register.
  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == RUN);
  assign load   = ready && start;
  assign step   = (state == RUN);
  assign finish = step && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers; the final step's result goes straight to p.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      p     <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        mcand <= a;
        mq    <= b;
        acc   <= '0;
        cnt   <= '0;
      end else if (step) begin
        acc <= acc_nxt;
        mq  <= mq_nxt;
        cnt <= cnt + CNT_W'(1);
        if (finish) begin
          p   <= {acc_nxt[OP_W-1:0], mq_nxt};
          ovf <= |acc_nxt[OP_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, scoreboard, corner sequences.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] p;
  logic        ovf;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   done_cnt;

  seq_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("sb_p", 32'(p), 32'(e.p));
        chk("sb_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.p   = 16'(x) * 16'(y);
    e.ovf = (e.p[15:8] != 8'd0);
    return e;
  endfunction

  // Waits for done, counting negedges from the cycle start was raised.
  task automatic wait_done(inout int lat);
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected 9", lat);
    end
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input exp_t e);
    int lat;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb_q.push_back(e);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(lat);
    chk("latency", 32'(lat), 32'd9);
  endtask

  vec_t vecs[11];

  initial begin
    int lat;
    int dc0;
    exp_t e;
    checks = 0; errors = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

    vecs[0]  = '{a: 8'd13,  b: 8'd11,  p: 16'd143,   ovf: 1'b0};
    vecs[1]  = '{a: 8'd255, b: 8'd255, p: 16'hFE01,  ovf: 1'b1};
    vecs[2]  = '{a: 8'd0,   b: 8'd200, p: 16'd0,     ovf: 1'b0};
    vecs[3]  = '{a: 8'd200, b: 8'd0,   p: 16'd0,     ovf: 1'b0};
    vecs[4]  = '{a: 8'd1,   b: 8'd1,   p: 16'd1,     ovf: 1'b0};
    vecs[5]  = '{a: 8'd15,  b: 8'd17,  p: 16'd255,   ovf: 1'b0};
    vecs[6]  = '{a: 8'd16,  b: 8'd16,  p: 16'd256,   ovf: 1'b1};
    vecs[7]  = '{a: 8'd255, b: 8'd1,   p: 16'd255,   ovf: 1'b0};
    vecs[8]  = '{a: 8'd1,   b: 8'd255, p: 16'd255,   ovf: 1'b0};
    vecs[9]  = '{a: 8'd128, b: 8'd2,   p: 16'd256,   ovf: 1'b1};
    vecs[10] = '{a: 8'd170, b: 8'd85,  p: 16'd14450, ovf: 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    // Table-driven products.
    for (int i = 0; i < 11; i++) begin
      e.p = vecs[i].p; e.ovf = vecs[i].ovf;
      run_op(vecs[i].a, vecs[i].b, e);
    end

    // Random products against the bench model.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      run_op(x, y, model(x, y));
    end

    // Start while busy is ignored; operands are not re-latched.
    @(negedge clk);
    dc0 = done_cnt;
    a = 8'd7; b = 8'd9; start = 1'b1;
    e.p = 16'd63; e.ovf = 1'b0;
    sb_q.push_back(e);
    lat = 0;
    @(negedge clk); start = 1'b0; lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    chk("busy_ready_low", 32'(ready), 32'd0);
    a = 8'd3; b = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0; lat++;
    wait_done(lat);
    chk("ignored_latency", 32'(lat), 32'd9);
    repeat (12) @(negedge clk);
    chk("ignored_one_done", 32'(done_cnt - dc0), 32'd1);

    // Back-to-back: second start issued during the DONE cycle.
    e.p = 16'd256; e.ovf = 1'b1;
    run_op(8'd16, 8'd16, e);
    a = 8'd2; b = 8'd5; start = 1'b1;
    chk("b2b_ready_in_done", 32'(ready), 32'd1);
    e.p = 16'd10; e.ovf = 1'b0;
    sb_q.push_back(e);
    lat = 0;
    @(negedge clk); start = 1'b0; lat = 1;
    chk("b2b_busy", 32'(busy), 32'd1);
    repeat (3) begin @(negedge clk); lat++; end
    chk("b2b_p_held", 32'(p), 32'd256);
    chk("b2b_ovf_held", 32'(ovf), 32'd1);
    wait_done(lat);
    chk("b2b_latency", 32'(lat), 32'd9);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    dc0 = done_cnt;
    a = 8'd100; b = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrst_p", 32'(p), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("midrst_idle_ready", 32'(ready), 32'd1);
    e.p = 16'd300; e.ovf = 1'b1;
    run_op(8'd100, 8'd3, e);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
